// File: rtl/mc_ctrl_fsm_if.sv
// mc_ctrl_fsm_if: instruction/flag/memory handshake and datapath control bundle
interface mc_ctrl_fsm_if #(parameter int INSTR_W = 16);
  logic [INSTR_W-1:0] instruction;
  logic               flag_z;
  logic               mem_ready;
  logic               mem_req;
  logic               pcEn;
  logic               pcIncOrSet;
  logic               irEn;
  logic               rfWe;
  logic               pcRegSel;
  logic               r2ImSel;
  logic               brWe;
  logic               wbRegAlu;
  logic [1:0]         immTypeSel;
  logic               err;
  logic [2:0]         state;
  modport master (
    output instruction, flag_z, mem_ready,
    input  mem_req, pcEn, pcIncOrSet, irEn, rfWe, pcRegSel, r2ImSel, brWe,
           wbRegAlu, immTypeSel, err, state
  );
  modport slave (
    input  instruction, flag_z, mem_ready,
    output mem_req, pcEn, pcIncOrSet, irEn, rfWe, pcRegSel, r2ImSel, brWe,
           wbRegAlu, immTypeSel, err, state
  );
endinterface

// File: rtl/mc_ctrl_fsm.sv
// mc_ctrl_fsm: multi-cycle fetch/decode/execute/mem/writeback controller with memory timeout
module mc_ctrl_fsm #(
  parameter int INSTR_W     = 16,
  parameter int TIMEOUT_CYC = 15
) (
  input  logic           clock,
  input  logic           reset,
  mc_ctrl_fsm_if.slave   bus
);
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  typedef enum logic [2:0] {
    FETCH = 3'd0, DECODE = 3'd1, EXECUTE = 3'd2, MEM = 3'd3, WB = 3'd4, ERROR = 3'd7
  } state_t;
  state_t        r_state;
  logic [CW-1:0] r_wait;
  logic          r_taken;
  logic          r_store;
  logic [3:0]    w_op;
  logic [3:0]    w_sub;
  logic [3:0]    w_cond;
  logic          w_load;
  logic          w_store;
  logic          w_branch;
  logic          w_immz;
  logic          w_imms;
  logic          w_upper;
  logic          w_undef;
  logic          w_taken;
  logic          w_ex;
  logic          w_wb;
  assign w_op     = bus.instruction[INSTR_W-1 -: 4];
  assign w_sub    = bus.instruction[7:4];
  assign w_cond   = bus.instruction[11:8];
  assign w_load   = w_op == 4'h4 && w_sub == 4'h0;
  assign w_store  = w_op == 4'h4 && w_sub == 4'h4;
  assign w_branch = w_op == 4'hC;
  assign w_immz   = w_op == 4'h1 || w_op == 4'h2 || w_op == 4'h3 || w_op == 4'hD;
  assign w_imms   = w_op == 4'h5 || w_op == 4'h9;
  assign w_upper  = w_op == 4'hF;
  assign w_undef  = w_op == 4'h6 || w_op == 4'h7 || w_op == 4'h8 || w_op == 4'hA ||
                    w_op == 4'hB || w_op == 4'hE || (w_op == 4'h4 && !w_load && !w_store);
  assign w_taken  = w_branch && ((w_cond == 4'h0 && bus.flag_z) || (w_cond == 4'h1 && !bus.flag_z));
  assign w_ex     = r_state == EXECUTE;
  assign w_wb     = r_state == WB;
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state <= FETCH;
      r_wait  <= '0;
      r_taken <= 1'b0;
      r_store <= 1'b0;
    end else begin
      case (r_state)
        FETCH, MEM: begin
          r_wait <= bus.mem_ready ? '0 : r_wait + CW'(1);
          if (bus.mem_ready) r_state <= (r_state == FETCH) ? DECODE : WB;
          else if (r_wait == CW'(TIMEOUT_CYC)) r_state <= ERROR;
        end
        DECODE: r_state <= EXECUTE;
        EXECUTE: begin
          r_taken <= w_taken;
          r_store <= w_store;
          r_wait  <= '0;
          r_state <= (w_load || w_store) ? MEM : WB;
        end
        WB: begin
          r_wait  <= '0;
          r_state <= FETCH;
        end
        ERROR: r_state <= ERROR;
        default: begin
          r_wait  <= '0;
          r_state <= FETCH;
        end
      endcase
    end
  end
  // MEM decisions use the store flag captured in EXECUTE, so the bus may change meanwhile
  assign bus.mem_req    = reset && (r_state == FETCH || r_state == MEM);
  assign bus.irEn       = r_state == DECODE;
  assign bus.pcEn       = w_wb;
  assign bus.rfWe       = w_wb && !w_store && !w_branch && !w_undef;
  assign bus.wbRegAlu   = !(w_wb && w_load);
  assign bus.pcIncOrSet = w_wb && w_branch && r_taken;
  assign bus.brWe       = r_state == MEM && r_store && bus.mem_ready;
  assign bus.pcRegSel   = !(w_ex && w_branch);
  assign bus.r2ImSel    = w_ex && (w_immz || w_imms || w_upper || w_branch);
  assign bus.immTypeSel = !w_ex ? 2'b00 : w_immz ? 2'b10 : (w_imms || w_branch) ? 2'b01 : 2'b00;
  assign bus.err        = r_state == ERROR;
  assign bus.state      = r_state;
endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// tb_mc_ctrl_fsm: randomized and directed checks of mc_ctrl_fsm against a per-cycle phase model
module tb_mc_ctrl_fsm;
  localparam int TO = 15;
  localparam int C_REG = 0, C_IMMZ = 1, C_IMMS = 2, C_UPPER = 3, C_BR = 4, C_LOAD = 5, C_STORE = 6, C_UNDEF = 7;
  logic clock = 1'b0;
  logic reset = 1'b0;
  int total = 0;
  int bad = 0;
  logic [15:0] q_act[$];
  logic [15:0] q_exp[$];
  mc_ctrl_fsm_if #(.INSTR_W(16)) bus ();
  mc_ctrl_fsm #(.INSTR_W(16), .TIMEOUT_CYC(TO)) dut (.clock(clock), .reset(reset), .bus(bus));
  always #5 clock = ~clock;
  function automatic int cls_of(logic [15:0] ins);
    case (ins[15:12])
      4'h0: return C_REG;
      4'h1, 4'h2, 4'h3, 4'hD: return C_IMMZ;
      4'h5, 4'h9: return C_IMMS;
      4'hF: return C_UPPER;
      4'hC: return C_BR;
      4'h4: return ins[7:4] == 4'h0 ? C_LOAD : ins[7:4] == 4'h4 ? C_STORE : C_UNDEF;
      default: return C_UNDEF;
    endcase
  endfunction
  // Expected outputs for one cycle spent in phase ph (0 fetch,1 decode,2 exec,3 mem,4 wb,7 error)
  function automatic logic [15:0] exp_vec(int ph, logic [15:0] ins, logic z, logic rdy, logic rst_n);
    int c = cls_of(ins);
    logic mr = 0, pe = 0, pis = 0, ir = 0, rf = 0, prs = 1, r2 = 0, bw = 0, wba = 1;
    logic [1:0] imm = 2'b00;
    logic tk = c == C_BR && ((ins[11:8] == 4'h0 && z) || (ins[11:8] == 4'h1 && !z));
    case (ph)
      0: mr = rst_n;
      1: ir = 1;
      2: begin
        r2  = c inside {C_IMMZ, C_IMMS, C_UPPER, C_BR};
        imm = c == C_IMMZ ? 2'b10 : (c == C_IMMS || c == C_BR) ? 2'b01 : 2'b00;
        prs = c != C_BR;
      end
      3: begin
        mr = 1;
        bw = c == C_STORE && rdy;
      end
      4: begin
        pe  = 1;
        rf  = c inside {C_REG, C_IMMZ, C_IMMS, C_UPPER, C_LOAD};
        wba = c != C_LOAD;
        pis = tk;
      end
      default: ;
    endcase
    return {mr, pe, pis, ir, rf, prs, r2, bw, wba, imm, ph == 7, 3'(ph)};
  endfunction
  function automatic logic [15:0] obs();
    return {bus.mem_req, bus.pcEn, bus.pcIncOrSet, bus.irEn, bus.rfWe, bus.pcRegSel, bus.r2ImSel,
            bus.brWe, bus.wbRegAlu, bus.immTypeSel, bus.err, bus.state};
  endfunction
  task automatic tick();
    @(posedge clock);
    #1;
  endtask
  task automatic sample(int ph, logic [15:0] ins, logic z, logic rdy);
    @(negedge clock);
    q_act.push_back(obs());
    q_exp.push_back(exp_vec(ph, ins, z, rdy, reset));
    tick();
  endtask
  // Runs one instruction from FETCH to the following FETCH; fd/md are mem_ready delays
  task automatic run_instr(logic [15:0] ins, logic z, int fd, int md);
    logic mem = cls_of(ins) inside {C_LOAD, C_STORE};
    q_act.delete();
    q_exp.delete();
    for (int k = 0; k <= fd; k++) begin
      bus.instruction = 16'($urandom);
      bus.flag_z = 1'($urandom);
      bus.mem_ready = k == fd;
      sample(0, ins, z, bus.mem_ready);
    end
    bus.instruction = ins;
    bus.mem_ready = 1'($urandom);
    bus.flag_z = 1'($urandom);
    sample(1, ins, z, 1'b0);
    bus.flag_z = z;
    bus.mem_ready = 1'($urandom);
    sample(2, ins, z, 1'b0);
    if (mem) begin
      for (int k = 0; k <= md; k++) begin
        bus.instruction = 16'($urandom);
        bus.flag_z = 1'($urandom);
        bus.mem_ready = k == md;
        sample(3, ins, z, bus.mem_ready);
      end
      bus.instruction = ins;
    end
    bus.mem_ready = 1'($urandom);
    bus.flag_z = 1'($urandom);
    sample(4, ins, z, 1'b0);
    bus.mem_ready = 1'b0;
  endtask
  task automatic do_reset();
    reset = 1'b0;
    bus.mem_ready = 1'b0;
    tick();
    reset = 1'b1;
  endtask
  task automatic test_reset();
    reset = 1'b0;
    bus.instruction = 16'h0000;
    bus.flag_z = 1'b0;
    bus.mem_ready = 1'b0;
    tick();
    tick();
    @(negedge clock);
    total++;
    if (obs() !== exp_vec(0, 16'h0, 1'b0, 1'b0, 1'b0)) begin
      bad++;
      $display("FAIL reset_hold got=%h exp=%h", obs(), exp_vec(0, 16'h0, 1'b0, 1'b0, 1'b0));
    end
    reset = 1'b1;
    #1;
    total++;
    if (obs() !== exp_vec(0, 16'h0, 1'b0, 1'b0, 1'b1)) begin
      bad++;
      $display("FAIL reset_release got=%h exp=%h", obs(), exp_vec(0, 16'h0, 1'b0, 1'b0, 1'b1));
    end
    tick();
  endtask
  task automatic test_directed();
    logic [15:0] ins[6] = '{16'h5123, 16'h4A0B, 16'h4A4B, 16'hC005, 16'hC105, 16'h0123};
    int fd[6] = '{0, 1, 0, 0, 0, TO};
    int md[6] = '{0, 3, 2, 0, 0, 0};
    for (int t = 0; t < 6; t++) begin
      run_instr(ins[t], 1'b1, fd[t], md[t]);
      total++;
      if (t == 0 && q_act.size() !== 4) begin
        bad++;
        $display("FAIL addi_len got=%0d exp=4", q_act.size());
      end
      foreach (q_exp[i]) begin
        total++;
        if (q_act[i] !== q_exp[i]) begin
          bad++;
          $display("FAIL directed ins=%h cyc=%0d got=%h exp=%h", ins[t], i, q_act[i], q_exp[i]);
        end
      end
    end
  endtask
  task automatic test_timeout();
    logic [15:0] e;
    for (int pass = 0; pass < 2; pass++) begin
      q_act.delete();
      q_exp.delete();
      if (pass == 1) begin
        bus.mem_ready = 1'b1;
        sample(0, 16'h4A0B, 1'b0, 1'b1);
        bus.instruction = 16'h4A0B;
        bus.mem_ready = 1'b0;
        sample(1, 16'h4A0B, 1'b0, 1'b0);
        sample(2, 16'h4A0B, 1'b0, 1'b0);
      end
      for (int k = 0; k <= TO; k++) begin
        bus.mem_ready = 1'b0;
        bus.instruction = 16'($urandom);
        sample(pass == 0 ? 0 : 3, 16'h4A0B, 1'b0, 1'b0);
      end
      for (int k = 0; k < 3; k++) begin
        bus.mem_ready = 1'b1;
        bus.instruction = 16'($urandom);
        sample(7, 16'h0, 1'b0, 1'b1);
      end
      foreach (q_exp[i]) begin
        total++;
        if (q_act[i] !== q_exp[i]) begin
          bad++;
          $display("FAIL timeout pass=%0d cyc=%0d got=%h exp=%h", pass, i, q_act[i], q_exp[i]);
        end
      end
      do_reset();
      @(negedge clock);
      e = exp_vec(0, 16'h0, 1'b0, 1'b0, 1'b1);
      total++;
      if (obs() !== e) begin
        bad++;
        $display("FAIL error_exit pass=%0d got=%h exp=%h", pass, obs(), e);
      end
      tick();
      do_reset();
    end
  endtask
  task automatic test_reset_mem();
    logic [15:0] e;
    bus.mem_ready = 1'b1;
    tick();
    bus.instruction = 16'h4A4B;
    bus.mem_ready = 1'b0;
    tick();
    tick();
    @(negedge clock);
    e = exp_vec(3, 16'h4A4B, 1'b0, 1'b0, 1'b1);
    total++;
    if (obs() !== e) begin
      bad++;
      $display("FAIL reset_mem_pre got=%h exp=%h", obs(), e);
    end
    reset = 1'b0;
    bus.mem_ready = 1'b1;
    tick();
    @(negedge clock);
    e = exp_vec(0, 16'h0, 1'b0, 1'b0, 1'b0);
    total++;
    if (obs() !== e) begin
      bad++;
      $display("FAIL reset_mem got=%h exp=%h", obs(), e);
    end
    reset = 1'b1;
    bus.mem_ready = 1'b0;
    tick();
  endtask
  task automatic test_random();
    for (int n = 0; n < 60; n++) begin
      logic [15:0] ins = 16'($urandom);
      int fd = $urandom_range(0, 9) == 0 ? TO : $urandom_range(0, 3);
      int md = $urandom_range(0, 9) == 0 ? TO : $urandom_range(0, 3);
      if (ins[15:12] == 4'h4 && $urandom_range(0, 2) != 0) ins[7:4] = $urandom_range(0, 1) ? 4'h0 : 4'h4;
      if (ins[15:12] == 4'hC && $urandom_range(0, 2) != 0) ins[11:8] = 4'($urandom_range(0, 1));
      run_instr(ins, 1'($urandom), fd, md);
      foreach (q_exp[i]) begin
        total++;
        if (q_act[i] !== q_exp[i]) begin
          bad++;
          $display("FAIL random ins=%h cyc=%0d got=%h exp=%h", ins, i, q_act[i], q_exp[i]);
        end
      end
    end
  endtask
  initial begin
    test_reset();
    test_directed();
    test_timeout();
    test_reset_mem();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
